bf_weight_loader: RTL

BF_WEIGHT_LOADER -- requirements
Module: bf_weight_loader

---
 rtl/bf_weight_loader_pkg.sv | 27 ++
 rtl/bf_weight_bank.sv | 39 +++
 rtl/bf_weight_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bf_weight_loader_pkg.sv
// bf_weight_loader_pkg: shared beamformer types and constants.
// Contents:
//   - default array geometry
//   - bank index constants
//   - weight-set register type
//   - loader FSM state encoding
package bf_weight_loader_pkg;

    localparam int DEF_NUM_ELEM = 8;
    localparam int DEF_W_WIDTH  = 5;
    localparam int NUM_BANKS    = 4;

    localparam logic [1:0] BANK_COS_1 = 2'd0;
    localparam logic [1:0] BANK_SIN_1 = 2'd1;
    localparam logic [1:0] BANK_COS_2 = 2'd2;
    localparam logic [1:0] BANK_SIN_2 = 2'd3;

    // Full weight set at the default geometry: bank, then element, then bit.
    typedef logic [NUM_BANKS-1:0][DEF_NUM_ELEM-1:0][DEF_W_WIDTH-1:0] weight_set_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/bf_weight_bank.sv
// bf_weight_bank: one 4-bank weight set, writable word-by-word or loaded whole.
// Ports:
//   clock, reset   - clock and asynchronous active-high clear
//   we, widx, wdata - single-word write at frame word index widx
//   load, load_data - copy an entire set in one cycle (takes priority over we)
//   q              - stored set
module bf_weight_bank
    import bf_weight_loader_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    parameter int W_WIDTH  = DEF_W_WIDTH,
    localparam int CW      = $clog2(NUM_BANKS * NUM_ELEM)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          we,
    input  logic [CW-1:0]                                 widx,
    input  logic [W_WIDTH-1:0]                            wdata,
    input  logic                                          load,
    input  logic [NUM_BANKS-1:0][NUM_ELEM-1:0][W_WIDTH-1:0] load_data,
    output logic [NUM_BANKS-1:0][NUM_ELEM-1:0][W_WIDTH-1:0] q
);

    // Word k lands in bank k / NUM_ELEM, element k mod NUM_ELEM; matching the
    // flat index avoids dividers for non power-of-two element counts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (we) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int e = 0; e < NUM_ELEM; e++)
                    if (widx == CW'(b * NUM_ELEM + e))
                        q[b][e] <= wdata;
        end
    end

endmodule

// File: rtl/bf_weight_loader.sv
// bf_weight_loader: framed weight loader with shadow/active double buffering.
// Ports:
//   clock, reset        - clock and asynchronous active-high reset
//   wr_valid/wr_sof/wr_data, wr_ready - weight word stream (accepted on valid & ready)
//   w_cos_1..w_sin_2    - active weights, NUM_ELEM x W_WIDTH each
//   weights_valid       - a frame has been committed since reset
//   commit_pulse        - strobe in the cycle the active set changes
//   frame_err           - strobe on an orphan word or a mid-frame restart
module bf_weight_loader
    import bf_weight_loader_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    parameter int W_WIDTH  = DEF_W_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_valid,
    input  logic                              wr_sof,
    input  logic [W_WIDTH-1:0]                wr_data,
    output logic                              wr_ready,
    output logic [NUM_ELEM-1:0][W_WIDTH-1:0]  w_cos_1,
    output logic [NUM_ELEM-1:0][W_WIDTH-1:0]  w_sin_1,
    output logic [NUM_ELEM-1:0][W_WIDTH-1:0]  w_cos_2,
    output logic [NUM_ELEM-1:0][W_WIDTH-1:0]  w_sin_2,
    output logic                              weights_valid,
    output logic                              commit_pulse,
    output logic                              frame_err
);

    localparam int CW = $clog2(NUM_BANKS * NUM_ELEM);
    localparam logic [CW-1:0] LAST = CW'(NUM_BANKS * NUM_ELEM - 1);

    state_t state;
    logic [CW-1:0] cnt;
    logic acc;
    logic shadow_we;
    logic [CW-1:0] widx;
    logic [NUM_BANKS-1:0][NUM_ELEM-1:0][W_WIDTH-1:0] shadow_q;
    logic [NUM_BANKS-1:0][NUM_ELEM-1:0][W_WIDTH-1:0] active_q;

    assign acc = wr_valid && wr_ready;
    // A sof word always restarts at index 0, whether it opens or resyncs a frame.
    assign widx = wr_sof ? '0 : cnt;
    // Orphan words in IDLE are dropped.
    assign shadow_we = acc && (wr_sof || state == LOAD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_ready      <= 1'b0;
            weights_valid <= 1'b0;
            commit_pulse  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            frame_err    <= 1'b0;
            wr_ready     <= 1'b1;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (wr_sof) begin
                            state <= LOAD;
                            cnt   <= CW'(1);
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (acc) begin
                        frame_err <= wr_sof;
                        if (widx == LAST) begin
                            state    <= COMMIT;
                            cnt      <= '0;
                            wr_ready <= 1'b0;
                        end else begin
                            cnt <= widx + CW'(1);
                        end
                    end
                end
                COMMIT: begin
                    state         <= IDLE;
                    commit_pulse  <= 1'b1;
                    weights_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bf_weight_bank #(.NUM_ELEM(NUM_ELEM), .W_WIDTH(W_WIDTH)) u_shadow (
        .clock     (clock),
        .reset     (reset),
        .we        (shadow_we),
        .widx      (widx),
        .wdata     (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .q         (shadow_q)
    );

    // The active set is loaded on the edge leaving COMMIT, so it only moves
    // when a complete frame sits in the shadow set.
    bf_weight_bank #(.NUM_ELEM(NUM_ELEM), .W_WIDTH(W_WIDTH)) u_active (
        .clock     (clock),
        .reset     (reset),
        .we        (1'b0),
        .widx      ('0),
        .wdata     ('0),
        .load      (state == COMMIT),
        .load_data (shadow_q),
        .q         (active_q)
    );

    assign w_cos_1 = active_q[BANK_COS_1];
    assign w_sin_1 = active_q[BANK_SIN_1];
    assign w_cos_2 = active_q[BANK_COS_2];
    assign w_sin_2 = active_q[BANK_SIN_2];

endmodule
